shifter_seq_ctrl: RTL

Sequencer for a bank of synchronous 74194-style 4-bit universal shift registers used as a tile/sprite pixel serializer. It accepts fetched pixel groups through a one-entry handshake buffer. Per pixel enable it issues a load, a shift or a clear, and drives the bank's mode (S1/S0), clear (CR_n) and clock-enable strobe, honouring horizontal flip. It sits between the video fetch logic and the serializer banks in the video pipeline.

---
 rtl/shifter_seq_ctrl_pkg.sv | 24 ++
 rtl/shifter_seq_ctrl_if.sv | 30 +++
 rtl/shifter_seq_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/shifter_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// shifter_seq_ctrl_pkg
// Shared definitions for the pixel serializer sequencer:
//   - sr_op_e   : {S1,S0} mode encodings of the 74194-style shift register bank
//   - state_e   : sequencer line state (IDLE outside the active span)
//   - PIX_IDX_W : width of the pixel-within-group index / group counter
// -----------------------------------------------------------------------------
package shifter_seq_ctrl_pkg;

    localparam int PIX_IDX_W = 2;

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_SHR  = 2'b01,
        OP_SHL  = 2'b10,
        OP_LOAD = 2'b11
    } sr_op_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

endpackage

// File: rtl/shifter_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// shifter_seq_ctrl_if
// Fetch-side handshake into the sequencer's one-entry group buffer.
// The pixel data itself goes straight to the bank D inputs; only the
// valid/ready handshake and the per-group horizontal flip travel here.
//   FETCH_VALID : fetch offers a pixel group
//   FETCH_FLIP  : horizontal flip of the offered group
//   FETCH_READY : buffer can accept (transfer on VALID && READY)
// Modports: master = fetch logic, slave = sequencer.
// -----------------------------------------------------------------------------
interface shifter_seq_ctrl_if;
    import shifter_seq_ctrl_pkg::*;

    logic FETCH_VALID;
    logic FETCH_FLIP;
    logic FETCH_READY;

    modport master (
        output FETCH_VALID,
        output FETCH_FLIP,
        input  FETCH_READY
    );

    modport slave (
        input  FETCH_VALID,
        input  FETCH_FLIP,
        output FETCH_READY
    );

endinterface

// File: rtl/shifter_seq_ctrl.sv
// -----------------------------------------------------------------------------
// shifter_seq_ctrl
// Sequencer for a bank of 74194-style 4-bit universal shift registers used as
// a tile/sprite pixel serializer. Per pixel enable it issues a LOAD (first
// pixel of a group), a shift (SHR, or SHL when the group is flipped) or a
// clear (group due but no fetched group available), and drives the shared
// bank controls.
//
// Ports:
//   CP          in   system clock, rising edge
//   Reset       in   synchronous, active-high
//   PIX_CE      in   one-CP pulse per pixel period
//   LINE_START  in   start of active span (with PIX_CE)
//   LINE_END    in   end of active span (with PIX_CE), wins over LINE_START
//   fetch       slave modport of shifter_seq_ctrl_if (VALID/FLIP/READY)
//   SR_S0/SR_S1 out  bank mode
//   SR_CR_n     out  bank clear, active-low
//   SR_CEN      out  bank clock-enable strobe (bank acts on its rising edge)
//   PIX_IDX     out  index within the group of the op last issued
//   UNDERRUN    out  sticky: a load was due with the buffer empty
//
// Latency: PIX_CE is registered at edge n, the op is registered onto the
// bank controls at edge n+1 and the strobe drops at edge n+2.
// -----------------------------------------------------------------------------
module shifter_seq_ctrl
    import shifter_seq_ctrl_pkg::*;
#(
    parameter int PIX_PER_LOAD = 4
) (
    input  logic                   CP,
    input  logic                   Reset,
    input  logic                   PIX_CE,
    input  logic                   LINE_START,
    input  logic                   LINE_END,
    shifter_seq_ctrl_if.slave      fetch,
    output logic                   SR_S0,
    output logic                   SR_S1,
    output logic                   SR_CR_n,
    output logic                   SR_CEN,
    output logic [PIX_IDX_W-1:0]   PIX_IDX,
    output logic                   UNDERRUN
);

    localparam logic [PIX_IDX_W-1:0] CNT_LAST = PIX_IDX_W'(PIX_PER_LOAD - 1);

    // Stage p0: registered pixel event
    logic                 pix_ce_p0;
    logic                 line_start_p0;
    logic                 line_end_p0;

    // Sequencer state
    state_e               state_q, state_d;
    logic [PIX_IDX_W-1:0] cnt_q, cnt_d;
    logic                 buf_valid_q, buf_valid_d;
    logic                 buf_flip_q, buf_flip_d;
    logic                 cur_flip_q, cur_flip_d;
    logic                 underrun_q, underrun_d;

    // Stage p1: registered bank controls
    sr_op_e               mode_p1, mode_d;
    logic                 cr_n_p1, cr_n_d;
    logic                 cen_p1, cen_d;
    logic [PIX_IDX_W-1:0] pix_idx_p1, pix_idx_d;

    logic                 issue;
    logic                 consume;
    logic                 accept;
    logic                 fetch_ready;

    // The LINE_START pixel is processed as an ACTIVE pixel in the same cycle,
    // so an issue happens either while active or on the starting pixel.
    assign issue       = pix_ce_p0 && ((state_q == ST_ACTIVE) || line_start_p0);
    assign consume     = issue && (cnt_q == '0) && buf_valid_q;
    assign fetch_ready = !Reset && (!buf_valid_q || consume);
    assign accept      = fetch.FETCH_VALID && fetch_ready;

    assign fetch.FETCH_READY = fetch_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        buf_valid_d = buf_valid_q;
        buf_flip_d  = buf_flip_q;
        cur_flip_d  = cur_flip_q;
        underrun_d  = underrun_q;
        mode_d      = mode_p1;
        cr_n_d      = cr_n_p1;
        cen_d       = 1'b0;
        pix_idx_d   = pix_idx_p1;

        if (issue) begin
            cen_d     = 1'b1;
            cr_n_d    = 1'b1;
            pix_idx_d = cnt_q;
            if (cnt_q == '0) begin
                if (buf_valid_q) begin
                    mode_d     = OP_LOAD;
                    cur_flip_d = buf_flip_q;
                end else begin
                    // Nothing fetched in time: blank the bank instead of
                    // replaying stale pixels.
                    mode_d     = OP_HOLD;
                    cr_n_d     = 1'b0;
                    underrun_d = 1'b1;
                end
            end else begin
                mode_d = cur_flip_q ? OP_SHL : OP_SHR;
            end

            if (line_end_p0) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                state_d = ST_ACTIVE;
                cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + PIX_IDX_W'(1);
            end
        end else if (cen_p1) begin
            // Strobe falling: keep the mode stable through the low cycle and
            // release a clear op so it lasts exactly the strobe cycle.
            cr_n_d = 1'b1;
        end else if (state_q == ST_IDLE) begin
            mode_d = OP_HOLD;
            cr_n_d = 1'b0;
        end

        // Flush on line end wins; a fetch landing on a consume cycle refills
        // the entry, and cur_flip above already took the outgoing flip.
        if (issue && line_end_p0) begin
            buf_valid_d = 1'b0;
        end else if (accept) begin
            buf_valid_d = 1'b1;
            buf_flip_d  = fetch.FETCH_FLIP;
        end else if (consume) begin
            buf_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CP) begin
        if (Reset) begin
            pix_ce_p0     <= 1'b0;
            line_start_p0 <= 1'b0;
            line_end_p0   <= 1'b0;
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            buf_valid_q   <= 1'b0;
            cur_flip_q    <= 1'b0;
            underrun_q    <= 1'b0;
            mode_p1       <= OP_HOLD;
            cr_n_p1       <= 1'b0;
            cen_p1        <= 1'b0;
            pix_idx_p1    <= '0;
        end else begin
            pix_ce_p0     <= PIX_CE;
            line_start_p0 <= LINE_START;
            line_end_p0   <= LINE_END;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            buf_valid_q   <= buf_valid_d;
            cur_flip_q    <= cur_flip_d;
            underrun_q    <= underrun_d;
            mode_p1       <= mode_d;
            cr_n_p1       <= cr_n_d;
            cen_p1        <= cen_d;
            pix_idx_p1    <= pix_idx_d;
        end
    end

    // The flip bit is only meaningful while buf_valid is set.
    always_ff @(posedge CP) begin
        buf_flip_q <= buf_flip_d;
    end

    assign SR_S0    = mode_p1[0];
    assign SR_S1    = mode_p1[1];
    assign SR_CR_n  = cr_n_p1;
    assign SR_CEN   = cen_p1;
    assign PIX_IDX  = pix_idx_p1;
    assign UNDERRUN = underrun_q;

endmodule
